// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//
// Shared definitions for the RISC-V core front end.
//   XLEN              architectural register / address width
//   RESET_PC_DEFAULT  default fetch address after reset
//   INSTR_NOP         canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t     {pc, instr} pair carried from fetch to decode
//   next_seq_pc()     sequential successor of a word-aligned PC
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Wraps modulo 2^XLEN, so 0xFFFF_FFFC is followed by 0x0000_0000.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//
// Synchronous FIFO of fetch_entry_t between instruction memory and decode.
// The head entry is always presented on head_o; the caller qualifies it with
// count_o != 0. A flush empties the FIFO in one cycle and wins over any push
// or pop in the same cycle. Storage is cleared by reset so the head reads as
// zero out of reset.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   flush_i      discard all entries
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        remove the head entry
//   head_o       current head entry
//   count_o      number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against the fill level and derive the next pointers.
  // A push into a full FIFO is only honoured when a pop frees a slot in the
  // same cycle; DEPTH is a power of two so the pointers wrap naturally.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flush only moves the pointers, stale data is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the fetch PC, issues in-order word fetches
// to instruction memory under a credit limit (buffered + in-flight <= DEPTH),
// buffers returned words with their PCs in fetch_fifo and hands them to
// decode. A redirect reloads the PC, empties the FIFO and marks every
// request still in flight to be dropped when its response comes back.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   redirect_en      taken jump/branch this cycle
//   redirect_pc      redirect target (low two bits ignored)
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts request
//   imem_req_addr    word-aligned fetch address
//   imem_resp_valid  response valid (in request order, no backpressure)
//   imem_resp_data   instruction word returned by memory
//   if_valid         instruction available to decode
//   if_ready         decode accepts instruction
//   if_instr         instruction word to decode
//   if_pc            PC of if_instr
// ---------------------------------------------------------------------------
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] fifo_cnt;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;
  logic [CNT_W:0]   in_use;
  logic [XLEN-1:0]  redirect_target;
  logic             req_fire;
  logic             resp_keep;
  logic             resp_drop;
  logic             if_pop;
  logic             unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit check: every slot is either buffered or reserved by an in-flight
  // request, so a kept response always finds room in the FIFO. Requests are
  // held off during a redirect and while reset is asserted.
  always_comb begin
    in_use         = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
    imem_req_valid = rst_n && !redirect_en && (in_use < (CNT_W + 1)'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
  end

  assign imem_req_addr = fetch_pc_q;

  // Response classification. Anything arriving while older wrong-path
  // requests are still draining, or in the redirect cycle itself, is dropped.
  always_comb begin
    resp_drop = imem_resp_valid && (redirect_en || (drop_q != '0));
    resp_keep = imem_resp_valid && !resp_drop;
  end

  // Next-state for the PC and counters.
  // resp_pc tracks the PC of the next response that will be kept: responses
  // come back in order, and after a redirect the first kept response is the
  // first request issued from the target, so no per-request tag is needed.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_d     = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = next_seq_pc(fetch_pc_q);
      end
      if (resp_keep) begin
        resp_pc_d = next_seq_pc(resp_pc_q);
      end
      if (resp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  // Architectural fetch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign fifo_wdata = '{pc: resp_pc_q, instr: imem_resp_data};
  assign if_valid   = (fifo_cnt != '0) && !redirect_en;
  assign if_pop     = if_valid && if_ready;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_en),
    .push_i     (resp_keep),
    .push_data_i(fifo_wdata),
    .pop_i      (if_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt)
  );

  assign if_pc    = fifo_head.pc;
  assign if_instr = fifo_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with DEPTH = 2 and a reset PC of zero. A
// small in-order memory model answers every accepted request one cycle
// later (or holds answers while memEnable is low). Issued addresses and
// delivered {pc, instr} pairs are logged in queues and compared against
// hand-derived sequences.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int          errors;
  int          checks;
  logic        memEnable;
  logic [31:0] pendingQ[$];
  logic [31:0] issuedQ[$];
  logic [31:0] pcQ[$];
  logic [31:0] instrQ[$];

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: every word is a fixed function of its address.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle. Called 1 unit after a rising edge; samples the DUT at
  // +2, logs handshakes, then after the edge updates the memory model.
  task automatic applyStimulus();
    logic        acc;
    logic [31:0] accAddr;
    #1;
    acc     = rst_n && imem_req_valid && imem_req_ready;
    accAddr = imem_req_addr;
    if (if_valid && if_ready) begin
      pcQ.push_back(if_pc);
      instrQ.push_back(if_instr);
    end
    if (acc) issuedQ.push_back(accAddr);
    @(posedge clk);
    #1;
    if (acc) pendingQ.push_back(accAddr);
    if (memEnable && (pendingQ.size() > 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memData(pendingQ.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic clearLogs();
    issuedQ.delete();
    pcQ.delete();
    instrQ.delete();
  endtask

  // Asserts reset, clears the memory model, releases 1 unit after an edge.
  task automatic doReset();
    rst_n           = 1'b0;
    redirect_en     = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    pendingQ.delete();
    clearLogs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic doRedirect(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    clearLogs();
    applyStimulus();
    redirect_en = 1'b0;
  endtask

  initial begin
    logic found;
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b1;
    redirect_en     = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if_ready        = 1'b1;
    memEnable       = 1'b1;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);

    // First cycle after release requests the reset PC.
    doReset();
    #1;
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);

    // Streaming with a 1-cycle memory and decode always ready.
    runCycles(12);
    checkOutput("stream_issued_enough", 32'(issuedQ.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) checkOutput("stream_req_addr", issuedQ[i], 32'(4 * i));
    checkOutput("stream_delivered_enough", 32'(pcQ.size() >= 6), 32'h1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("stream_if_pc", pcQ[i], 32'(4 * i));
      checkOutput("stream_if_instr", instrQ[i], memData(32'(4 * i)));
    end

    // Decode stalled for 10 cycles: credit limit caps issue at DEPTH.
    doReset();
    if_ready = 1'b0;
    runCycles(10);
    checkOutput("stall_issue_count", 32'(issuedQ.size()), 32'h2);
    checkOutput("stall_if_valid", 32'(if_valid), 32'h1);
    checkOutput("stall_if_pc", if_pc, 32'h0);
    checkOutput("stall_if_instr", if_instr, memData(32'h0));
    if_ready = 1'b1;
    runCycles(10);
    checkOutput("stall_release_count", 32'(pcQ.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_release_pc", pcQ[i], 32'(4 * i));
      checkOutput("stall_release_instr", instrQ[i], memData(32'(4 * i)));
    end

    // Redirect to 0x100 with two requests in flight.
    doReset();
    memEnable = 1'b0;
    runCycles(2);
    checkOutput("redir_pre_issued", 32'(issuedQ.size()), 32'h2);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checkOutput("redir_req_valid_low", 32'(imem_req_valid), 32'h0);
    doRedirect(32'h0000_0100);
    memEnable = 1'b1;
    checkOutput("redir_next_addr", imem_req_addr, 32'h0000_0100);
    runCycles(10);
    checkOutput("redir_issued_first", issuedQ[0], 32'h0000_0100);
    checkOutput("redir_delivered_any", 32'(pcQ.size() >= 2), 32'h1);
    checkOutput("redir_first_if_pc", pcQ[0], 32'h0000_0100);
    checkOutput("redir_first_if_instr", instrQ[0], memData(32'h0000_0100));
    checkOutput("redir_second_if_pc", pcQ[1], 32'h0000_0104);

    // Redirect coinciding with a response while decode is ready.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_resp_valid && if_valid) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("coinc_setup_found", 32'(found), 32'h1);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    checkOutput("coinc_if_valid_low", 32'(if_valid), 32'h0);
    doRedirect(32'h0000_0300);
    checkOutput("coinc_fifo_empty", 32'(if_valid), 32'h0);
    runCycles(10);
    checkOutput("coinc_first_if_pc", pcQ[0], 32'h0000_0300);
    checkOutput("coinc_first_if_instr", instrQ[0], memData(32'h0000_0300));

    // Misaligned target is forced to a word boundary.
    doRedirect(32'h0000_0203);
    checkOutput("align_req_addr", imem_req_addr, 32'h0000_0200);
    runCycles(10);
    checkOutput("align_issued_first", issuedQ[0], 32'h0000_0200);
    checkOutput("align_first_if_pc", pcQ[0], 32'h0000_0200);

    // Fetch PC wraps past the top of the address space.
    doRedirect(32'hFFFF_FFFC);
    checkOutput("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    runCycles(10);
    checkOutput("wrap_issued_0", issuedQ[0], 32'hFFFF_FFFC);
    checkOutput("wrap_issued_1", issuedQ[1], 32'h0000_0000);
    checkOutput("wrap_if_pc_0", pcQ[0], 32'hFFFF_FFFC);
    checkOutput("wrap_if_pc_1", pcQ[1], 32'h0000_0000);
    checkOutput("wrap_if_instr_1", instrQ[1], memData(32'h0000_0000));

    // Asynchronous reset mid-stream with buffered instructions.
    if_ready = 1'b0;
    runCycles(3);
    checkOutput("areset_pre_if_valid", 32'(if_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("areset_req_addr", imem_req_addr, 32'h0);
    checkOutput("areset_if_valid", 32'(if_valid), 32'h0);
    checkOutput("areset_if_pc", if_pc, 32'h0);
    checkOutput("areset_if_instr", if_instr, 32'h0);
    doReset();
    if_ready = 1'b1;
    #1;
    checkOutput("areset_restart_addr", imem_req_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
